// File: rtl/icache_axi_rd_master.sv
// AXI4 read-burst master for I-cache line fills: one 4-beat INCR burst per miss, words strobed back one per beat.
// Optional read-error checking is enabled with `define ICACHE_RD_ERR_CHK_EN; otherwise rd_err is tied low.
module icache_axi_rd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter logic [ID_W-1:0] AR_ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic              axi_valid,
  output logic [DATA_W-1:0] I_out,
  output logic              axi_ready,
  output logic              rd_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic [1:0] beat_cnt;
  logic       beat_acc;

  assign ARID     = AR_ID;
  assign ARLEN    = 8'd3;
  assign ARSIZE   = 3'b010;
  assign ARBURST  = 2'b01;
  assign beat_acc = (state == DATA) && RVALID && RREADY;

  // Line offset bits are never used: the burst always starts at the line base.
  logic unused_offset;
  assign unused_offset = ^I_addr[3:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= 2'd0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      RREADY    <= 1'b0;
      axi_ready <= 1'b0;
      I_out     <= '0;
    end else begin
      axi_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (axi_valid && I_req) begin
            ARADDR   <= {I_addr[ADDR_W-1:4], 4'h0};
            beat_cnt <= 2'd0;
            ARVALID  <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat_acc) begin
            I_out     <= RDATA;
            axi_ready <= 1'b1;
            beat_cnt  <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              RREADY <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_RD_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_err <= 1'b0;
    end else if (beat_acc) begin
      if ((RRESP != 2'b00) || (RID != AR_ID) || (RLAST != (beat_cnt == 2'd3)))
        rd_err <= 1'b1;
    end
  end
`else
  assign rd_err = 1'b0;

  logic unused_chk;
  assign unused_chk = ^{RRESP, RID, RLAST};
`endif

endmodule

// File: tb/tb_icache_axi_rd_master.sv
// Directed bench for icache_axi_rd_master: fills with AR stalls, RVALID gaps, stray pulses, mid-burst reset and error responses.
module tb_icache_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req;
  logic [31:0] I_addr;
  logic        axi_valid;
  logic [31:0] I_out;
  logic        axi_ready;
  logic        rd_err;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_err = 1'b0;

  icache_axi_rd_master dut (
    .clk(clk), .rst(rst), .I_req(I_req), .I_addr(I_addr), .axi_valid(axi_valid),
    .I_out(I_out), .axi_ready(axi_ready), .rd_err(rd_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input bit vld, input int beat, input logic [31:0] dbase, input int err_beat);
    RVALID = vld;
    RDATA  = vld ? dbase + 32'(beat) : 32'hDEAD_BEEF;
    RLAST  = vld && (beat == 3);
    RRESP  = (vld && beat == err_beat) ? 2'b10 : 2'b00;
    RID    = 4'h0;
  endtask

  // One full fill; rv_pat[i] is the RVALID value for the i-th data-phase cycle.
  task automatic do_fill(input logic [31:0] addr, input int ar_wait, input logic [15:0] rv_pat,
                         input int rv_len, input logic [31:0] dbase, input int err_beat,
                         input bit stray_pulse);
    int beat = 0;
    int ar_hs = 0;
    logic [31:0] last;
    I_req = 1'b1; I_addr = addr; axi_valid = 1'b1;
    tick();
    axi_valid = 1'b0;
    check("arvalid_rise", ARVALID, 1);
    check("araddr", ARADDR, {addr[31:4], 4'h0});
    for (int w = 0; w < ar_wait; w++) begin
      ARREADY = 1'b0;
      tick();
      check("arvalid_hold", ARVALID, 1);
      check("araddr_hold", ARADDR, {addr[31:4], 4'h0});
    end
    ARREADY = 1'b1;
    if (ARVALID) ar_hs++;
    tick();
    ARREADY = 1'b0;
    check("arvalid_drop", ARVALID, 0);
    check("rready_up", RREADY, 1);
    for (int i = 0; i < rv_len; i++) begin
      drive_beat(rv_pat[i], beat, dbase, err_beat);
      if (stray_pulse && i == 1) axi_valid = 1'b1;
`ifdef ICACHE_RD_ERR_CHK_EN
      if (rv_pat[i] && beat == err_beat) exp_err = 1'b1;
`endif
      tick();
      axi_valid = 1'b0;
      check("axi_ready_pat", axi_ready, rv_pat[i]);
      if (rv_pat[i]) begin
        check("i_out_beat", I_out, dbase + 32'(beat));
        last = dbase + 32'(beat);
        beat++;
      end else if (beat > 0) begin
        check("i_out_hold", I_out, last);
      end
      check("no_second_ar", ARVALID, 0);
      check("rd_err", rd_err, exp_err);
    end
    drive_beat(1'b0, 0, dbase, err_beat);
    check("strobe_count", beat, 4);
    check("ar_handshakes", ar_hs, 1);
    check("rready_idle", RREADY, 0);
    tick();
    check("axi_ready_idle", axi_ready, 0);
    check("rready_stays_low", RREADY, 0);
    I_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; I_req = 1'b0; I_addr = '0; axi_valid = 1'b0; ARREADY = 1'b0;
    drive_beat(1'b0, 0, 0, -1);
    tick(); tick();
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_axi_ready", axi_ready, 0);
    check("rst_i_out", I_out, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_rd_err", rd_err, 0);
    check("arlen", ARLEN, 3);
    check("arsize", ARSIZE, 2);
    check("arburst", ARBURST, 1);
    check("arid", ARID, 0);
    rst = 1'b1;
    tick();

    // axi_valid without I_req is ignored
    axi_valid = 1'b1; I_req = 1'b0; I_addr = 32'h0000_5550;
    tick();
    axi_valid = 1'b0;
    check("ignore_no_req", ARVALID, 0);
    tick();

    do_fill(32'h0000_1234, 0, 16'b1111, 4, 32'h0000_00A0, -1, 1'b0);
    do_fill(32'h8000_0FF8, 5, 16'b1111, 4, 32'h0000_00B0, -1, 1'b0);
    // RVALID 1,0,0,1,1,0,1 (bit 0 first)
    do_fill(32'h0000_2000, 0, 16'b1011001, 7, 32'h0000_00C0, -1, 1'b0);
    do_fill(32'h0000_3010, 1, 16'b1111, 4, 32'h0000_00D0, -1, 1'b1);

    // Reset after beat 2, then a fresh fill
    I_req = 1'b1; I_addr = 32'h0000_4444; axi_valid = 1'b1;
    tick();
    axi_valid = 1'b0; ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(1'b1, b, 32'h0000_00E0, -1);
      tick();
      check("pre_rst_beat", I_out, 32'h0000_00E0 + 32'(b));
    end
    drive_beat(1'b0, 0, 0, -1);
    rst = 1'b0;
    tick();
    check("midrst_arvalid", ARVALID, 0);
    check("midrst_rready", RREADY, 0);
    check("midrst_axi_ready", axi_ready, 0);
    check("midrst_i_out", I_out, 0);
    rst = 1'b1; I_req = 1'b0;
    tick();
    do_fill(32'h0000_1234, 0, 16'b1111, 4, 32'h0000_00F0, -1, 1'b0);

    // Error response on beat 1: data still delivered, flag sticky
    do_fill(32'h0000_6000, 0, 16'b1111, 4, 32'h0000_0100, 1, 1'b0);
    tick(); tick();
    check("rd_err_sticky", rd_err, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
